top_multicycle: RTL and testbench
=================================

# top_multicycle

Multi-cycle successor of the single-cycle CPU top. It reuses the existing Controller, Registers, ALU, sign_extend and Jump_Ctrl datapath blocks and sequences each instruction through an IF/ID/EX/MEM/WB state machine. It talks to instruction and data memories over req/ready handshakes, so memories may insert any number of wait states. It also exports a retired-instruction counter for bench and performance checks.

## Interface
- data_size, 32, datapath and memory word width
- mem_size, 16, word-address width of both memories
- pc_size, 18, byte PC width; must equal mem_size+2
- cnt_size, 32, retired-instruction counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- IM_req  out  1  instruction fetch request
- IM_Address  out  mem_size  word address, PC[pc_size-1:2]
- IM_ready  in  1  fetch complete; Instruction valid this cycle
- Instruction  in  data_size  fetched word
- DM_req  out  1  data access request
- DM_enable  out  1  write enable, qualified by DM_req
- DM_Address  out  mem_size  ALUOut[mem_size+1:2]
- DM_Write_Data  out  data_size  latched Rt value
- DM_ready  in  1  access complete; DM_Read_Data valid this cycle
- DM_Read_Data  in  data_size  load data
- state  out  3  current FSM state (debug)
- retire_cnt  out  cnt_size  number of instructions retired

## Operation
- Internal registers: PC, IR, A (Rs), B (Rt), ALUOut, MDR, state, retire_cnt.
- FSM states and encodings are IDLE=0, IF=1, ID=2, EX=3, MEM=4 and WB=5.
- **IDLE:** entered only from reset. Moves to IF on the next edge.
- **IF:**
  - IM_req=1 and IM_Address=PC, both held stable until IM_ready.
  - On IM_ready: IR <= Instruction, go to ID.
- **ID:** A <= RF[Rs], B <= RF[Rt], Controller decodes IR. Go to EX.
- **EX:**
  - ALUOut <= ALU(A, Reg_imm ? se_imm : B, shamt).
  - Jump_Ctrl selects the next PC:
    - branch: PC+4+(se_imm<<2)
    - jr: A[pc_size-1:0]
    - j/jal: {imm,2'b0}
    - otherwise: PC+4
  - Branch-not-taken, branch-taken, j and jr update PC, retire, and go to IF.
  - lw/sw go to MEM. ALU ops and jal go to WB.
- **MEM:**
  - DM_req=1; DM_enable=1 for sw only. Address and data held until DM_ready.
  - On DM_ready, lw does MDR <= DM_Read_Data and goes to WB.
  - On DM_ready, sw does PC <= PC+4, retires, and goes to IF.
- **WB:**
  - Write address: jal uses 31, else Reg_imm ? Rt : Rd.
  - Write data: jal uses {zero-pad, PC+8}, else MemtoReg ? MDR : ALUOut.
  - PC <= next PC, retire, go to IF.
- Writes to register 0 are suppressed; RegWrite is asserted only in WB.
- Retire means retire_cnt increments by 1 and wraps modulo 2^cnt_size.
- PC arithmetic is modulo 2^pc_size. Branch offset uses se_imm[15:0] shifted left by 2, truncated to pc_size.
- Ready inputs are ignored while the matching req is low.

## Timing
- Reset (rst=0, asynchronous) sets these values immediately:
  - state=IDLE, PC=0, IR=0, retire_cnt=0
  - IM_req=0, DM_req=0, DM_enable=0
  - IM_Address=0, DM_Address=0, DM_Write_Data=0
- Reset mid-transaction drops req at once and aborts the instruction: no register write, no PC update, no retire.
- First IM_req appears 1 cycle after rst deasserts (IDLE→IF).
- IM_req, DM_req and DM_enable are decoded from state (Moore). They drop on the edge that samples ready.
- With zero-wait memories (ready in the same cycle as req), cycles per instruction are:
  - branch/j/jr: 3
  - ALU/jal/sw: 4
  - lw: 5
- Each memory wait cycle adds exactly 1 cycle.
- A register written in WB is visible to the next instruction's ID. There are no hazards.
- retire_cnt updates on the same edge as the final PC update of the instruction.

## Test plan
- **Reset/fetch:** hold rst=0 for 3 cycles, release, IM_ready tied 1.
  - During reset: all outputs 0 and state=0.
  - Cycle 1 after release: IM_req=1, IM_Address=0.
- **ALU + wait states:** addi $1,$0,5 then add $2,$1,$1, with IM_ready delayed 2 cycles per fetch.
  - $2=10, retire_cnt=2.
  - Each instruction takes 6 cycles.
  - IM_Address stays stable while waiting.
- **Load/store:** sw $2,8($0) then lw $3,8($0), DM_ready delayed 1 cycle.
  - DM_req with DM_enable=1, DM_Address=2, DM_Write_Data=10.
  - Then DM_req with DM_enable=0; $3=10.
  - The lw takes 6 cycles.
- **Control flow:** all with zero-wait memories.
  - beq taken, offset 3, at PC=0x10: next IM_Address=0x8 (PC 0x20), 3 cycles.
  - jal with imm=0x40: next PC=0x100, $31=PC+8.
  - jr $31: PC returns to the saved value.
- **Reset mid-MEM:** assert rst while DM_req=1 for an sw.
  - DM_req drops in the same cycle; no register write.
  - After release, PC=0 and retire_cnt=0.
- **Register 0 / wrap:** with cnt_size=4, run 17 instructions including addi $0,$0,7.
  - $0 reads 0.
  - retire_cnt=1 after wrap.

Source files
------------

// File: rtl/top_multicycle.sv
// Multi-cycle MIPS-subset CPU: IF/ID/EX/MEM/WB sequencer with
// req/ready instruction and data memory ports and a retire counter.
module top_multicycle #(
  parameter int data_size = 32,
  parameter int mem_size  = 16,
  parameter int pc_size   = 18,
  parameter int cnt_size  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 IM_req,
  output logic [mem_size-1:0]  IM_Address,
  input  logic                 IM_ready,
  input  logic [data_size-1:0] Instruction,
  output logic                 DM_req,
  output logic                 DM_enable,
  output logic [mem_size-1:0]  DM_Address,
  output logic [data_size-1:0] DM_Write_Data,
  input  logic                 DM_ready,
  input  logic [data_size-1:0] DM_Read_Data,
  output logic [2:0]           state,
  output logic [cnt_size-1:0]  retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR,
    A_NOR, A_SLT, A_SLL, A_SRL, A_SRA
  } alu_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] F_JR    = 6'h08;

  state_e               state_q, state_d;
  logic [pc_size-1:0]   pc_q, pc_d;
  logic [data_size-1:0] ir_q, ir_d;
  logic [data_size-1:0] a_q, a_d;
  logic [data_size-1:0] b_q, b_d;
  logic [data_size-1:0] alu_q, alu_d;
  logic [data_size-1:0] mdr_q, mdr_d;
  logic [cnt_size-1:0]  cnt_q, cnt_d;
  logic [data_size-1:0] rf_q [32];

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, shamt;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign fn    = ir_q[5:0];

  logic [data_size-1:0] se_imm;
  assign se_imm = {{(data_size-16){ir_q[15]}}, ir_q[15:0]};

  alu_e alu_op;
  logic reg_imm, reg_wr, mem_to_reg;
  logic is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_jal, is_jr;

  always_comb begin
    alu_op     = A_ADD;
    reg_imm    = 1'b0;
    reg_wr     = 1'b0;
    mem_to_reg = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    is_jal     = 1'b0;
    is_jr      = 1'b0;
    unique case (1'b1)
      (op == OP_R) && (fn == F_JR): is_jr = 1'b1;
      (op == OP_R) && (fn != F_JR): begin
        reg_wr = 1'b1;
        unique case (fn)
          6'h20:   alu_op = A_ADD;
          6'h22:   alu_op = A_SUB;
          6'h24:   alu_op = A_AND;
          6'h25:   alu_op = A_OR;
          6'h26:   alu_op = A_XOR;
          6'h27:   alu_op = A_NOR;
          6'h2a:   alu_op = A_SLT;
          6'h00:   alu_op = A_SLL;
          6'h02:   alu_op = A_SRL;
          6'h03:   alu_op = A_SRA;
          default: reg_wr = 1'b0;
        endcase
      end
      op == OP_J:   is_j   = 1'b1;
      op == OP_JAL: is_jal = 1'b1;
      op == OP_BEQ: is_beq = 1'b1;
      op == OP_BNE: is_bne = 1'b1;
      op == OP_ADDI: begin
        reg_imm = 1'b1;
        reg_wr  = 1'b1;
      end
      op == OP_SLTI: begin
        reg_imm = 1'b1;
        reg_wr  = 1'b1;
        alu_op  = A_SLT;
      end
      op == OP_LW: begin
        reg_imm    = 1'b1;
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        is_lw      = 1'b1;
      end
      op == OP_SW: begin
        reg_imm = 1'b1;
        is_sw   = 1'b1;
      end
      default: ;
    endcase
  end

  logic [data_size-1:0] src_b, alu_res;
  always_comb begin
    src_b   = reg_imm ? se_imm : b_q;
    alu_res = '0;
    unique case (alu_op)
      A_ADD:   alu_res = a_q + src_b;
      A_SUB:   alu_res = a_q - src_b;
      A_AND:   alu_res = a_q & src_b;
      A_OR:    alu_res = a_q | src_b;
      A_XOR:   alu_res = a_q ^ src_b;
      A_NOR:   alu_res = ~(a_q | src_b);
      A_SLT:   alu_res[0] = $signed(a_q) < $signed(src_b);
      A_SLL:   alu_res = src_b << shamt;
      A_SRL:   alu_res = src_b >> shamt;
      A_SRA:   alu_res = $signed(src_b) >>> shamt;
      default: alu_res = a_q + src_b;
    endcase
  end

  // next-PC selection; pc_q is stable from IF until retire
  logic [pc_size-1:0]   pc4, pc8, pc_br, jtgt, npc;
  logic [data_size-1:0] br_off;
  logic                 taken;
  assign pc4    = pc_q + pc_size'(4);
  assign pc8    = pc_q + pc_size'(8);
  assign br_off = se_imm << 2;
  assign pc_br  = pc4 + br_off[pc_size-1:0];
  assign jtgt   = {ir_q[pc_size-3:0], 2'b00};
  assign taken  = (is_beq && (a_q == b_q)) ||
                  (is_bne && (a_q != b_q));

  always_comb begin
    npc = pc4;
    unique case (1'b1)
      taken:           npc = pc_br;
      is_jr:           npc = a_q[pc_size-1:0];
      is_j || is_jal:  npc = jtgt;
      default:         npc = pc4;
    endcase
  end

  logic [4:0]           wr_addr;
  logic [data_size-1:0] wr_data;
  logic                 rf_we;
  assign wr_addr = is_jal ? 5'd31 : (reg_imm ? rt : rd);
  assign wr_data = is_jal     ? data_size'(pc8) :
                   mem_to_reg ? mdr_q : alu_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    rf_we   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_IF;
      S_IF: begin
        if (IM_ready) begin
          ir_d    = Instruction;
          state_d = S_ID;
        end
      end
      S_ID: begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        state_d = S_EX;
      end
      S_EX: begin
        alu_d = alu_res;
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (reg_wr || is_jal) begin
          state_d = S_WB;
        end else begin
          pc_d    = npc;
          cnt_d   = cnt_q + cnt_size'(1);
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (DM_ready) begin
          if (is_sw) begin
            pc_d    = pc4;
            cnt_d   = cnt_q + cnt_size'(1);
            state_d = S_IF;
          end else begin
            mdr_d   = DM_Read_Data;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = wr_addr != 5'd0;
        pc_d    = npc;
        cnt_d   = cnt_q + cnt_size'(1);
        state_d = S_IF;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      if (rf_we) rf_q[wr_addr] <= wr_data;
    end
  end

  assign IM_req        = state_q == S_IF;
  assign IM_Address    = pc_q[pc_size-1:2];
  assign DM_req        = state_q == S_MEM;
  assign DM_enable     = (state_q == S_MEM) && is_sw;
  assign DM_Address    = alu_q[mem_size+1:2];
  assign DM_Write_Data = b_q;
  assign state         = state_q;
  assign retire_cnt    = cnt_q;

endmodule

// File: tb/tb_top_multicycle.sv
// Bench for top_multicycle: memory responders with wait states,
// a data-access scoreboard, an ALU vector table and control-flow sequences.
module tb_top_multicycle;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IM_req, DM_req, DM_enable;
  logic [15:0] IM_Address, DM_Address;
  logic        IM_ready = 1'b0;
  logic        DM_ready = 1'b0;
  logic [31:0] Instruction = '0;
  logic [31:0] DM_Read_Data = '0;
  logic [31:0] DM_Write_Data;
  logic [2:0]  state;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  top_multicycle #(.cnt_size(CW)) dut (
    .clk(clk), .rst(rst),
    .IM_req(IM_req), .IM_Address(IM_Address),
    .IM_ready(IM_ready), .Instruction(Instruction),
    .DM_req(DM_req), .DM_enable(DM_enable),
    .DM_Address(DM_Address), .DM_Write_Data(DM_Write_Data),
    .DM_ready(DM_ready), .DM_Read_Data(DM_Read_Data),
    .state(state), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } dm_exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  dm_exp_t     dq[$];
  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  int n_vec = 0, n_err = 0;
  int im_wait = 0, dm_wait = 0;
  int im_cnt = 0, dm_cnt = 0;
  logic [15:0] im_lat = '0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f,
    input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
    input logic [4:0] sh);
    return {6'h00, s, t, d, sh, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op,
    input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op,
    input logic [25:0] tg);
    return {op, tg};
  endfunction

  task automatic exp_st(input logic [15:0] a, input logic [31:0] d);
    dq.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_ld(input logic [15:0] a);
    dq.push_back('{we: 1'b0, addr: a, data: 32'h0});
  endtask

  // instruction memory responder
  always @(negedge clk) begin
    if (IM_req) begin
      if (im_cnt == 0) im_lat = IM_Address;
      if (im_cnt >= im_wait) begin
        if (im_cnt > 0) check("im_addr_stable", 32'(IM_Address), 32'(im_lat));
        IM_ready    = 1'b1;
        Instruction = imem[IM_Address[9:0]];
      end else begin
        IM_ready = 1'b0;
      end
      im_cnt++;
    end else begin
      IM_ready = 1'b0;
      im_cnt   = 0;
    end
  end

  // data memory responder and scoreboard
  always @(negedge clk) begin
    if (DM_req) begin
      if (dm_cnt >= dm_wait) begin
        DM_ready = 1'b1;
        if (dq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL dm_unexpected: got we=%b addr=%h, want none",
                   DM_enable, DM_Address);
        end else begin
          dm_exp_t e;
          e = dq.pop_front();
          check("dm_we", 32'(DM_enable), 32'(e.we));
          check("dm_addr", 32'(DM_Address), 32'(e.addr));
          if (e.we) check("dm_wdata", DM_Write_Data, e.data);
        end
        if (DM_enable) dmem[DM_Address[9:0]] = DM_Write_Data;
        DM_Read_Data = dmem[DM_Address[9:0]];
      end else begin
        DM_ready = 1'b0;
      end
      dm_cnt++;
    end else begin
      DM_ready = 1'b0;
      dm_cnt   = 0;
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
  endtask

  task automatic rst_on();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic rst_off();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_retire(output int cyc);
    logic [CW-1:0] prev;
    prev = retire_cnt;
    cyc  = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (retire_cnt != prev) break;
      if (cyc > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL retire_timeout: got no retire, want one");
        break;
      end
    end
  endtask

  task automatic drain(input string nm, input int lim);
    int k;
    k = 0;
    while (dq.size() != 0 && k < lim) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(nm, dq.size(), 0);
  endtask

  vec_t tbl[14];

  initial begin
    int c, pw;

    tbl[0]  = '{6'h00, 6'h20, 16'd7,    16'd5,    5'd0, 32'd12};
    tbl[1]  = '{6'h00, 6'h22, 16'd5,    16'd7,    5'd0, 32'hFFFFFFFE};
    tbl[2]  = '{6'h00, 6'h24, 16'h0F0F, 16'h00FF, 5'd0, 32'h0000000F};
    tbl[3]  = '{6'h00, 6'h25, 16'h0F00, 16'h00F0, 5'd0, 32'h00000FF0};
    tbl[4]  = '{6'h00, 6'h26, 16'h00FF, 16'h0F0F, 5'd0, 32'h00000FF0};
    tbl[5]  = '{6'h00, 6'h27, 16'h0000, 16'h0000, 5'd0, 32'hFFFFFFFF};
    tbl[6]  = '{6'h00, 6'h2a, 16'hFFFF, 16'h0001, 5'd0, 32'd1};
    tbl[7]  = '{6'h00, 6'h2a, 16'h0001, 16'hFFFF, 5'd0, 32'd0};
    tbl[8]  = '{6'h00, 6'h00, 16'h0000, 16'h0003, 5'd4, 32'h00000030};
    tbl[9]  = '{6'h00, 6'h02, 16'h0000, 16'hFFF0, 5'd4, 32'h0FFFFFFF};
    tbl[10] = '{6'h00, 6'h03, 16'h0000, 16'hFFF0, 5'd4, 32'hFFFFFFFF};
    tbl[11] = '{6'h08, 6'h00, 16'h7FFF, 16'h0001, 5'd0, 32'h00008000};
    tbl[12] = '{6'h0a, 6'h00, 16'hFFFB, 16'hFFFC, 5'd0, 32'd1};
    tbl[13] = '{6'h0a, 6'h00, 16'h0003, 16'hFFFC, 5'd0, 32'd0};

    for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;

    // reset state and first fetch
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    repeat (3) @(negedge clk);
    check("rst_ctl", {IM_req, DM_req, DM_enable, state}, 32'h0);
    check("rst_addr", {IM_Address, DM_Address}, 32'h0);
    check("rst_wdata", DM_Write_Data, 32'h0);
    check("rst_cnt", 32'(retire_cnt), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_fetch", {IM_req, state, IM_Address}, {12'h0, 1'b1, 3'd1, 16'h0});

    // ALU with fetch waits, then store/load with data waits
    rst_on();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_r(6'h20, 5'd1, 5'd1, 5'd2, 5'd0);
    imem[2] = enc_i(6'h2b, 5'd0, 5'd2, 16'd8);
    imem[3] = enc_i(6'h23, 5'd0, 5'd3, 16'd8);
    imem[4] = enc_i(6'h2b, 5'd0, 5'd3, 16'd12);
    imem[5] = enc_j(6'h02, 26'd5);
    exp_st(16'd2, 32'd10);
    exp_ld(16'd2);
    exp_st(16'd3, 32'd10);
    im_wait = 2;
    dm_wait = 1;
    rst_off();
    wait_retire(c);
    check("addi_cyc", c, 7);
    wait_retire(c);
    check("add_cyc", c, 6);
    check("alu_cnt", 32'(retire_cnt), 32'd2);
    im_wait = 0;
    wait_retire(c);
    check("sw_cyc", c, 5);
    wait_retire(c);
    check("lw_cyc", c, 6);
    wait_retire(c);
    check("sw2_cyc", c, 5);
    check("ls_drain", dq.size(), 0);

    // control flow, zero-wait memories
    rst_on();
    clear_imem();
    dm_wait = 0;
    imem[0]    = enc_i(6'h08, 5'd0, 5'd5, 16'd1);
    imem[1]    = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
    imem[2]    = enc_i(6'h08, 5'd0, 5'd7, 16'd3);
    imem[3]    = enc_i(6'h08, 5'd0, 5'd8, 16'd0);
    imem[4]    = enc_i(6'h04, 5'd5, 5'd6, 16'd3);
    imem[5]    = enc_i(6'h2b, 5'd0, 5'd5, 16'h7C);
    imem[6]    = enc_i(6'h2b, 5'd0, 5'd5, 16'h7C);
    imem[7]    = enc_i(6'h2b, 5'd0, 5'd5, 16'h7C);
    imem[8]    = enc_j(6'h03, 26'h40);
    imem[9]    = enc_i(6'h2b, 5'd0, 5'd5, 16'h7C);
    imem[10]   = enc_i(6'h2b, 5'd0, 5'd31, 16'h40);
    imem[11]   = enc_i(6'h05, 5'd5, 5'd6, 16'd5);
    imem[12]   = enc_j(6'h02, 26'd12);
    imem[16'h40] = enc_i(6'h2b, 5'd0, 5'd31, 16'h44);
    imem[16'h41] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
    exp_st(16'h11, 32'h28);
    exp_st(16'h10, 32'h28);
    rst_off();
    repeat (4) wait_retire(c);
    wait_retire(c);
    check("beq_cyc", c, 3);
    check("beq_target", 32'(IM_Address), 32'h8);
    wait_retire(c);
    check("jal_cyc", c, 4);
    check("jal_target", 32'(IM_Address), 32'h40);
    wait_retire(c);
    wait_retire(c);
    check("jr_cyc", c, 3);
    check("jr_target", 32'(IM_Address), 32'hA);
    wait_retire(c);
    wait_retire(c);
    check("bne_nt_cyc", c, 3);
    check("bne_nt_next", 32'(IM_Address), 32'hC);
    check("cf_drain", dq.size(), 0);

    // ALU vector table
    rst_on();
    clear_imem();
    pw = 0;
    for (int k = 0; k < 14; k++) begin
      imem[pw] = enc_i(6'h08, 5'd0, 5'd1, tbl[k].a);
      pw++;
      imem[pw] = enc_i(6'h08, 5'd0, 5'd2, tbl[k].b);
      pw++;
      if (tbl[k].op == 6'h00)
        imem[pw] = enc_r(tbl[k].fn, 5'd1, 5'd2, 5'd3, tbl[k].sh);
      else
        imem[pw] = enc_i(tbl[k].op, 5'd1, 5'd3, tbl[k].b);
      pw++;
      imem[pw] = enc_i(6'h2b, 5'd0, 5'd3, 16'(16'h100 + 4 * k));
      pw++;
      exp_st(16'(16'h40 + k), tbl[k].exp);
    end
    imem[pw] = enc_j(6'h02, 26'(pw));
    rst_off();
    drain("alu_drain", 3000);

    // register 0 and retire counter wrap
    rst_on();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    imem[1] = enc_i(6'h2b, 5'd0, 5'd0, 16'h80);
    for (int k = 2; k < 16; k++) imem[k] = enc_i(6'h08, 5'd4, 5'd4, 16'd1);
    imem[16] = enc_j(6'h02, 26'd16);
    exp_st(16'h20, 32'h0);
    rst_off();
    for (int k = 1; k <= 17; k++) begin
      wait_retire(c);
      if (k == 16) check("cnt_wrap0", 32'(retire_cnt), 32'd0);
      if (k == 17) check("cnt_wrap1", 32'(retire_cnt), 32'd1);
    end
    check("r0_drain", dq.size(), 0);

    // reset in the middle of a store
    rst_on();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    imem[1] = enc_i(6'h2b, 5'd0, 5'd1, 16'd0);
    imem[2] = enc_j(6'h02, 26'd2);
    dm_wait = 5;
    rst_off();
    c = 0;
    while (!DM_req && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("mem_reached", 32'(DM_req), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ctl", {DM_req, DM_enable, state}, 32'h0);
    check("abort_cnt", 32'(retire_cnt), 32'h0);
    exp_st(16'h0, 32'd9);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("restart_fetch", {IM_req, IM_Address}, {15'h0, 1'b1, 16'h0});
    check("restart_cnt", 32'(retire_cnt), 32'h0);
    drain("abort_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
